// File: rtl/prog_loader.sv
// prog_loader: program-memory writer for the CDEC core.
// Takes a length-prefixed byte stream over valid/ready and writes the payload into
// program RAM through adrs/data/wr_en. The CPU is held in reset until a full image lands.
// Optional feature macro: CHECKSUM_EN adds a trailing checksum byte that must make the
// 8-bit sum of payload + checksum equal zero.
module prog_loader #(
  parameter logic [7:0] BASE_ADRS = 8'h00,
  parameter int         TIMEOUT   = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] adrs,
  output logic [7:0] data,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
`ifdef CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);
  localparam bit          TMO_EN    = (TIMEOUT > 0);

  state_t      state;
  state_t      next_state;
  logic [8:0]  count;
  logic [8:0]  idx;
  logic [31:0] tmo_cnt;
  logic        accept;
  logic        restart;
  logic        last_byte;
  logic        tmo_hit;

`ifdef CHECKSUM_EN
  logic [7:0]  sum;
  logic [7:0]  chk_total;
  assign chk_total = sum + in_data;
`endif

  assign accept    = in_valid && in_ready;
  assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign last_byte = ((idx + 9'd1) == count);
  // A byte accepted on the limit cycle suppresses the timeout.
  assign tmo_hit   = TMO_EN && !accept && ((tmo_cnt + 32'd1) == TMO_LIMIT);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: stream sequencing, timeout abort, checksum verdict.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LEN;
      end
      LEN: begin
        if (accept)       next_state = DATA;
        else if (tmo_hit) next_state = ERR;
      end
      DATA: begin
        if (accept)       next_state = WRITE;
        else if (tmo_hit) next_state = ERR;
      end
      WRITE: begin
        if (last_byte) begin
`ifdef CHECKSUM_EN
          next_state = CHK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = DATA;
        end
      end
`ifdef CHECKSUM_EN
      CHK: begin
        if (accept)       next_state = (chk_total == 8'h00) ? DONE : ERR;
        else if (tmo_hit) next_state = ERR;
      end
`endif
      DONE: begin
        if (start) next_state = LEN;
      end
      ERR: begin
        if (start) next_state = LEN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from the current state; the CPU runs only once an image is complete.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      LEN:  begin in_ready = 1'b1; busy = 1'b1; end
      DATA: begin in_ready = 1'b1; busy = 1'b1; end
      WRITE: begin wr_en = 1'b1; busy = 1'b1; end
`ifdef CHECKSUM_EN
      CHK:  begin in_ready = 1'b1; busy = 1'b1; end
`endif
      DONE: begin done = 1'b1; cpu_hold = 1'b0; end
      ERR:  begin error = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: length/index bookkeeping, write address/data capture, idle counter, running sum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      adrs    <= BASE_ADRS;
      data    <= 8'h00;
      count   <= 9'd0;
      idx     <= 9'd0;
      tmo_cnt <= 32'd0;
`ifdef CHECKSUM_EN
      sum     <= 8'h00;
`endif
    end else begin
      if (restart || accept) begin
        tmo_cnt <= 32'd0;
      end else if (in_ready) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
`ifdef CHECKSUM_EN
      if (restart) begin
        sum <= 8'h00;
      end else if ((state == DATA) && accept) begin
        sum <= sum + in_data;
      end
`endif
      case (state)
        LEN: begin
          if (accept) begin
            count <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
            idx   <= 9'd0;
          end
        end
        DATA: begin
          if (accept) begin
            data <= in_data;
            adrs <= BASE_ADRS + idx[7:0];
          end
        end
        WRITE: begin
          idx <= idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a write scoreboard.
// The DUT is built with BASE_ADRS=FE so every image exercises address wrap, and TIMEOUT=10.
module tb_prog_loader;

  localparam logic [7:0] BASE = 8'hFE;
  localparam int         TMO  = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] adrs;
  logic [7:0] data;
  logic       wr_en;
  logic       busy;
  logic       done;
  logic       error;
  logic       cpu_hold;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [7:0]  model_sum;

  // Flag patterns, ordered {in_ready, wr_en, busy, done, error, cpu_hold}.
  localparam logic [15:0] F_IDLE  = 16'b000001;
  localparam logic [15:0] F_RECV  = 16'b101001;
  localparam logic [15:0] F_WRITE = 16'b011001;
  localparam logic [15:0] F_DONE  = 16'b000100;
  localparam logic [15:0] F_ERR   = 16'b000011;

  always #5 clock = ~clock;

  prog_loader #(.BASE_ADRS(BASE), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .adrs(adrs), .data(data),
    .wr_en(wr_en), .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  function automatic logic [15:0] flags();
    return {10'b0, in_ready, wr_en, busy, done, error, cpu_hold};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one byte after 'gap' idle cycles and hold it until the loader takes it.
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!in_ready && waited < 64);
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_wait observed=in_ready low expected=byte %0h accepted within 64 cycles", b);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_len(input logic [7:0] n, input int gap);
    model_sum = 8'h00;
    apply_stimulus(n, gap);
  endtask

  task automatic send_payload(input int ofs, input logic [7:0] b, input int gap);
    exp_q.push_back({8'(int'(BASE) + ofs), b});
    model_sum = model_sum + b;
    apply_stimulus(b, gap);
  endtask

  // Finish the image: checksum byte when that feature is built in, otherwise one more cycle.
  task automatic close_image();
`ifdef CHECKSUM_EN
    apply_stimulus(8'(-model_sum), 0);
`else
    tick();
`endif
  endtask

  // Scoreboard: every write strobe must match the next expected address/data pair.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write observed=%h@%h expected=no write", data, adrs);
      end else begin
        exp_w = exp_q.pop_front();
        check_output("write_adrs_data", {adrs, data}, exp_w);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=simulation still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #2 reset_n = 1'b0;
    tick();
    tick();
    check_output("reset_flags", flags(), F_IDLE);
    check_output("reset_adrs", {8'h00, adrs}, {8'h00, BASE});
    check_output("reset_data", {8'h00, data}, 16'h0000);
    reset_n = 1'b1;
    tick();
    check_output("idle_flags", flags(), F_IDLE);

    // Basic load: 03, 01, 06, 46
    pulse_start();
    check_output("start_len_flags", flags(), F_RECV);
    send_len(8'h03, 0);
    send_payload(0, 8'h01, 0);
    send_payload(1, 8'h06, 0);
    send_payload(2, 8'h46, 0);
    check_output("last_write_not_done", flags(), F_WRITE);
    close_image();
    check_output("basic_done_flags", flags(), F_DONE);
    check_output("basic_drained", 16'(exp_q.size()), 16'd0);

`ifndef CHECKSUM_EN
    // Trailing byte offered in DONE is never taken
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check_output("trailing_byte_ignored", flags(), F_DONE);
`endif

    // Restart from DONE, back-pressure gaps, start while busy ignored
    pulse_start();
    check_output("restart_from_done", flags(), F_RECV);
    send_len(8'h02, 3);
    send_payload(0, 8'hAA, 3);
    pulse_start();
    send_payload(1, 8'hBB, 3);
    close_image();
    check_output("gapped_done_flags", flags(), F_DONE);
    check_output("gapped_drained", 16'(exp_q.size()), 16'd0);

    // Length 0 means 256 bytes, addresses wrap past FF
    pulse_start();
    send_len(8'h00, 0);
    for (int i = 0; i < 256; i++) send_payload(i, 8'(i), 0);
    close_image();
    check_output("len256_done_flags", flags(), F_DONE);
    check_output("len256_drained", 16'(exp_q.size()), 16'd0);

    // Bytes arriving on the exact timeout cycle win
    pulse_start();
    send_len(8'h01, TMO - 1);
    send_payload(0, 8'h77, TMO - 1);
    close_image();
    check_output("tmo_edge_done_flags", flags(), F_DONE);

    // Timeout: 05, 11 then idle
    pulse_start();
    send_len(8'h05, 0);
    send_payload(0, 8'h11, 0);
    repeat (TMO) tick();
    check_output("tmo_not_yet", flags(), F_RECV);
    tick();
    check_output("tmo_err_flags", flags(), F_ERR);
    check_output("tmo_drained", 16'(exp_q.size()), 16'd0);

`ifdef CHECKSUM_EN
    // Checksum good then bad
    pulse_start();
    apply_stimulus(8'h02, 0);
    exp_q.push_back({BASE, 8'h10});
    apply_stimulus(8'h10, 0);
    exp_q.push_back({8'(BASE + 8'h01), 8'h20});
    apply_stimulus(8'h20, 0);
    apply_stimulus(8'hD0, 0);
    check_output("chk_good_done", flags(), F_DONE);
    pulse_start();
    apply_stimulus(8'h02, 0);
    exp_q.push_back({BASE, 8'h10});
    apply_stimulus(8'h10, 0);
    exp_q.push_back({8'(BASE + 8'h01), 8'h20});
    apply_stimulus(8'h20, 0);
    apply_stimulus(8'hD1, 0);
    check_output("chk_bad_err", flags(), F_ERR);
    check_output("chk_drained", 16'(exp_q.size()), 16'd0);
`endif

    // Restart from ERR, then asynchronous reset in the middle of DATA
    pulse_start();
    check_output("restart_from_err", flags(), F_RECV);
    send_len(8'h04, 0);
    send_payload(0, 8'hC3, 0);
    tick();
    check_output("mid_session_data", flags(), F_RECV);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_flags", flags(), F_IDLE);
    check_output("async_reset_adrs", {8'h00, adrs}, {8'h00, BASE});
    check_output("async_reset_data", {8'h00, data}, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("post_reset_idle", flags(), F_IDLE);
    check_output("final_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program-memory writer for the CDEC core: the writing end of the program-store interface that the CPU reads through adrs/q.
- Accepts a length-prefixed byte stream from a serial receiver over a valid/ready handshake.
- Writes the payload into program RAM through adrs/data/wr_en.
- Holds the CPU in reset until a complete image is stored.

Parameters:
BASE_ADRS, 8'h00, first program address written; addresses wrap modulo 256
TIMEOUT, 0, max idle cycles between accepted bytes while loading; 0 disables the timeout

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte this cycle
adrs  output  8  program-memory write address
data  output  8  program-memory write data
wr_en  output  1  program-memory write strobe, one cycle per byte
busy  output  1  load session in progress
done  output  1  image loaded successfully (level)
error  output  1  load aborted (level)
cpu_hold  output  1  hold CPU in reset

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: state IDLE; in_ready=0, adrs=BASE_ADRS, data=0, wr_en=0, busy=0, done=0, error=0, cpu_hold=1.
- Byte accepted on a rising edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=0. start -> LEN; clears done/error and sets busy=1, cpu_hold=1.
  - LEN: in_ready=1. Accepted byte N is the payload length (N=0 means 256); count<=N, idx<=0 -> DATA.
  - DATA: in_ready=1. Accepted byte -> data<=byte, adrs<=BASE_ADRS+idx (8-bit wrap) -> WRITE.
  - WRITE: in_ready=0, wr_en=1 for exactly this cycle; adrs/data stable; idx<=idx+1.
    - Last byte -> CHK (CHECKSUM_EN) or DONE.
    - Otherwise -> DATA.
  - DONE: busy=0, done=1, cpu_hold=0; stays until start or reset.
  - ERR: busy=0, error=1, cpu_hold=1; stays until start or reset.
- Latency: wr_en is asserted the cycle after acceptance. Maximum throughput is one byte per two cycles.
- wr_en is never asserted outside WRITE, and never for LEN or checksum bytes.
- start while busy=1 is ignored.
- start in DONE or ERR restarts the session and reasserts cpu_hold the next cycle.
- in_valid without in_ready: no effect. The byte must be held by the source.
- Timeout (TIMEOUT>0): a counter clears on each accepted byte and on entry to LEN. It increments in LEN/DATA/CHK while no byte is accepted. Reaching TIMEOUT -> ERR.
- A byte accepted on the same cycle the counter would reach TIMEOUT wins; no error.
- Reset mid-session: immediate return to reset values. Partially written memory is not cleared.
- Address wrap: BASE_ADRS=8'hFE, N=4 writes FE, FF, 00, 01.

Optional Feature:
CHECKSUM_EN
- Defined: after the last payload byte, state CHK accepts one checksum byte C.
  - (sum of payload bytes + C) mod 256 == 0 -> DONE; otherwise -> ERR.
  - The running sum is cleared on entry to LEN.
- Not defined: no CHK state; the last WRITE goes directly to DONE. A trailing byte is not accepted (in_ready=0 in DONE).

Test Plan:
- Basic load: start, stream 03,01,06,46 with in_valid held high -> wr_en pulses at adrs 00/01/02 with data 01/06/46; done=1, cpu_hold=0 after the third write.
- Back-pressure: stream 02,AA,BB with in_valid gapped 3 cycles between bytes (TIMEOUT=0) -> exactly two writes, AA@00 and BB@01; no duplicate writes.
- Length 0 / wrap: BASE_ADRS=FE, N=00, 256 bytes of value i -> 256 writes, first FE<-00, then FF<-01, 00<-02; done=1.
- Timeout: TIMEOUT=10, start, send 05,11, then idle 10 cycles -> error=1, cpu_hold=1, busy=0, one write only (11@00).
- Checksum (CHECKSUM_EN): 02,10,20,D0 -> done=1. Repeat with 02,10,20,D1 -> error=1 with both writes performed.
- Reset/restart: assert reset_n low during the DATA state -> all outputs return to reset values within the cycle. start during busy is ignored; start from DONE re-enters LEN with cpu_hold=1.
